// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   div_state_e : controller FSM states (IDLE, PREP, ITER, FIX)
//   DIV_DATA_W  : default operand width
package div_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   acc_i  [2*DATA_W:0] : accumulator {upper (DATA_W+1 bits), quotient/dividend (DATA_W bits)}
//   dvsr_i [DATA_W-1:0] : divisor magnitude
//   acc_o  [2*DATA_W:0] : accumulator after shift / trial subtract / restore, new quotient bit in [0]
module div_step
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic [2*DATA_W:0]  acc_i,
   input  logic [DATA_W-1:0]  dvsr_i,
   output logic [2*DATA_W:0]  acc_o
);

   logic [2*DATA_W:0] sh;
   logic [DATA_W:0]   diff;
   // The upper part always stays below the divisor, so the MSB is zero on
   // entry and is dropped by the shift.
   logic              unused_msb;

   assign unused_msb = acc_i[2*DATA_W];
   assign sh         = {acc_i[2*DATA_W-1:0], 1'b0};
   assign diff       = sh[2*DATA_W:DATA_W] - {1'b0, dvsr_i};

   // Negative trial difference: keep the shifted value (restore), q bit = 0.
   always_comb begin
      acc_o = sh;
      if (!diff[DATA_W]) begin
         acc_o[2*DATA_W:DATA_W] = diff;
         acc_o[0]               = 1'b1;
      end
   end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle restoring divider sequencer (one iteration per clock).
//   clock, clear_n           : rising-edge clock, synchronous active-low reset
//   start                    : request, accepted only in IDLE
//   a_dividend, b_divisor    : operands, captured on the accept edge
//   busy                     : high from accept edge until the edge raising done
//   done                     : one-cycle completion pulse
//   dbz                      : divide-by-zero flag, held until next accept
//   c_quotient_and_remainder : {remainder, quotient}, held until next completion
// Build option: define DIV_SIGNED_EN for two's-complement operands; default is unsigned.
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a_dividend,
   input  logic [DATA_W-1:0]     b_divisor,
   output logic                  busy,
   output logic                  done,
   output logic                  dbz,
   output logic [2*DATA_W-1:0]   c_quotient_and_remainder
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int ACC_W = 2*DATA_W + 1;

   div_state_e          state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                dbz_q, dbz_d;
   logic [2*DATA_W-1:0] res_q, res_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [ACC_W-1:0]    acc_step;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W-1:0]   q_fix, r_fix;

`ifdef DIV_SIGNED_EN
   // Raw operands are kept so their signs are still known in FIX.
   assign a_mag = a_q[DATA_W-1] ? -a_q : a_q;
   assign b_mag = b_q[DATA_W-1] ? -b_q : b_q;
   // Quotient truncates toward zero; remainder follows the dividend sign.
   // Most-negative / -1 falls out naturally: magnitude 2^(W-1) / 1, no negate.
   assign q_fix = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -acc_q[DATA_W-1:0]
                                                  :  acc_q[DATA_W-1:0];
   assign r_fix = a_q[DATA_W-1] ? -acc_q[2*DATA_W-1:DATA_W]
                                :  acc_q[2*DATA_W-1:DATA_W];
`else
   assign a_mag = a_q;
   assign b_mag = b_q;
   assign q_fix = acc_q[DATA_W-1:0];
   assign r_fix = acc_q[2*DATA_W-1:DATA_W];
`endif

   div_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .acc_i  (acc_q),
      .dvsr_i (b_mag),
      .acc_o  (acc_step)
   );

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      res_d   = res_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_dividend;
               b_d     = b_divisor;
               busy_d  = 1'b1;
               dbz_d   = 1'b0;
               state_d = PREP;
            end
         end
         PREP: begin
            if (b_q == '0) begin
               dbz_d   = 1'b1;
               state_d = FIX;
            end else begin
               acc_d   = {(DATA_W+1)'(0), a_mag};
               cnt_d   = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1))
               state_d = FIX;
         end
         FIX: begin
            // Divide by zero: remainder = dividend, quotient = all ones.
            if (dbz_q)
               res_d = {a_q, {DATA_W{1'b1}}};
            else
               res_d = {r_fix, q_fix};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         res_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         res_q   <= res_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy                     = busy_q;
   assign done                     = done_q;
   assign dbz                      = dbz_q;
   assign c_quotient_and_remainder = res_q;

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Multi-cycle sequencer for the CPU's 32-bit restoring divider, replacing the single-cycle combinational divide in the ALU's DIV path. It accepts a start pulse, performs one shift/subtract/restore iteration per clock, and writes a 64-bit {remainder, quotient} result for the HI/LO registers. Its busy/done handshake lets the control unit stall the datapath during a divide instead of stretching the clock period.

## Interface
- DATA_W, 32: operand width; the iteration count equals DATA_W.
- clock  input  1  rising-edge clock.
- clear_n  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  input  1  request; sampled only in IDLE.
- a_dividend  input  DATA_W  dividend; captured on the edge that accepts start.
- b_divisor  input  DATA_W  divisor; captured on the edge that accepts start.
- busy  output  1  high from the accept edge until the edge that raises done. Reset value 0.
- done  output  1  one-cycle completion pulse. Reset value 0.
- dbz  output  1  divide-by-zero flag, valid while done is high and held until the next accept. Reset value 0.
- c_quotient_and_remainder  output  2*DATA_W  [2*DATA_W-1:DATA_W] holds the remainder (HI); [DATA_W-1:0] holds the quotient (LO). Reset value 0. Holds its value until the next completion.

## Operation
- **States:** IDLE, PREP, ITER, FIX.
- **IDLE:**
  - If start = 1: capture the operands, set busy, go to PREP.
  - If start = 0: stay in IDLE.
- **PREP:**
  - If the divisor is 0: set dbz and go to FIX.
  - Otherwise: load the accumulator with {(DATA_W+1)'b0, dividend magnitude}, clear the iteration counter and go to ITER.
- **ITER**, once per clock:
  - Shift the accumulator left by 1.
  - Form upper part = upper part − divisor magnitude, computed at DATA_W+1 bits.
  - If the sign bit is 1, restore the upper part and set q[0] = 0; otherwise set q[0] = 1.
  - Increment the counter. After DATA_W iterations, go to FIX.
- **FIX:**
  - Write the result; apply sign correction if configured.
  - Pulse done, clear busy and return to IDLE.
- **Divide by zero:** quotient = all ones; remainder = dividend.
- **Arithmetic:** the counter is $clog2(DATA_W+1) bits wide. No arithmetic overflow is possible in unsigned mode.
- **start while busy:** ignored. It is not queued, and the operands are not re-captured.
- **start in the same cycle as done:** not accepted, because the FSM is still in FIX. The request is accepted on the following cycle if start remains high.
- **clear_n = 0 at any point:** on the next edge the FSM returns to IDLE and all outputs take their reset values. Any partial result is discarded.

## Timing
- Let the accept edge be E.
  - PREP executes at edge E+1.
  - ITER occupies edges E+2 through E+DATA_W+1.
  - FIX executes at edge E+DATA_W+2, so done is high during the cycle after that edge.
  - For DATA_W = 32, done rises 34 edges after the accept edge.
- **Divide by zero:** done rises at edge E+2.
- **busy:** high throughout, from E up to the edge at which done rises.
- **done:** high for exactly one cycle.
- **Back-to-back divides:** minimum start-to-start spacing is DATA_W+3 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- **DIV_SIGNED_EN defined:** operands are treated as two's-complement.
  - PREP takes magnitudes of both operands.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. The quotient truncates toward zero.
  - Most-negative / −1: quotient = most-negative value, remainder = 0, no flag.
  - Divide by zero: same result as in unsigned mode.
- **DIV_SIGNED_EN undefined:** unsigned only. PREP and FIX perform no sign handling, and the magnitude logic is not synthesised.

## Structure
- **Package div_pkg:** state enum (IDLE, PREP, ITER, FIX) and the DATA_W default constant.
- **Sub-module div_step:**
  - Purely combinational; performs one restoring iteration (shift, subtract, restore, quotient bit).
  - Input: accumulator and divisor. Output: next accumulator.
  - Instantiated once inside the controller.

## Test plan
- 100 / 7, unsigned -> done at edge E+34; result: remainder 2, quotient 14; busy high for 34 cycles.
- 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; 5 / 0 -> dbz = 1, quotient 0xFFFFFFFF, remainder 5, done at E+2.
- start re-pulsed mid-divide with new operands -> ignored; the first result is unaffected and only one done pulse occurs.
- clear_n = 0 at iteration 10 -> busy, done and result are 0 on the next edge; a fresh 9 / 3 then returns quotient 3, remainder 0.
- DIV_SIGNED_EN: −7 / 2 -> quotient −3, remainder −1; 0x80000000 / −1 -> quotient 0x80000000, remainder 0.
- Back-to-back: 20 / 6 then 50 / 5, with start held high -> second request accepted the cycle after done; results (2, 3) then (0, 10).
